// File: rtl/common_pkg.sv
// Shared register identifiers and fetch sequencer state encoding for the 16-bit core.
package common_pkg;

  typedef enum logic [3:0] {
    R_ZR  = 4'd0,
    R_IP  = 4'd1,
    R_IR1 = 4'd2,
    R_IR2 = 4'd3,
    R_SP  = 4'd4,
    R_R0  = 4'd5,
    R_R1  = 4'd6,
    R_R2  = 4'd7,
    R_R3  = 4'd8
  } reg_id_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD1  = 3'd1,
    WB1  = 3'd2,
    INC1 = 3'd3,
    RD2  = 3'd4,
    WB2  = 3'd5,
    INC2 = 3'd6,
    DONE = 3'd7
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads one or two words at IP into IR1/IR2 and advances IP,
// all through the register file's single write port.
module instr_fetch
  import common_pkg::*;
#(
  parameter logic [15:0] EXT_MASK  = 16'hF000,
  parameter logic [15:0] EXT_MATCH = 16'hF000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_mem_req,
  output logic [15:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [15:0] i_mem_rdata,
  output logic        o_rf_wr_en,
  output reg_id_e     o_rf_dest_addr,
  output logic [15:0] o_rf_dest_data,
  output reg_id_e     o_rf_ab_addr,
  input  logic [15:0] i_rf_ab_data
);

  fetch_state_e state_q, state_d;
  logic [15:0]  ip_q, ip_d;
  logic [15:0]  word_q, word_d;
  logic         ext_q, ext_d;
  logic [15:0]  ip_inc;

  assign ip_inc       = ip_q + 16'd1;
  assign o_rf_ab_addr = R_IP;

  // Next-state logic. Outputs depend only on state_q and registers, never on i_mem_ack.
  always_comb begin
    state_d        = state_q;
    ip_d           = ip_q;
    word_d         = word_q;
    ext_d          = ext_q;
    o_busy         = 1'b1;
    o_done         = 1'b0;
    o_mem_req      = 1'b0;
    o_mem_addr     = 16'h0000;
    o_rf_wr_en     = 1'b0;
    o_rf_dest_addr = R_ZR;
    o_rf_dest_data = 16'h0000;

    case (state_q)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          ip_d    = i_rf_ab_data;
          state_d = RD1;
        end
      end
      RD1, RD2: begin
        o_mem_req  = 1'b1;
        o_mem_addr = ip_q;
        if (i_mem_ack) begin
          word_d  = i_mem_rdata;
          state_d = (state_q == RD1) ? WB1 : WB2;
        end
      end
      WB1: begin
        o_rf_wr_en     = 1'b1;
        o_rf_dest_addr = R_IR1;
        o_rf_dest_data = word_q;
        ext_d          = ((word_q & EXT_MASK) == EXT_MATCH);
        state_d        = INC1;
      end
      WB2: begin
        o_rf_wr_en     = 1'b1;
        o_rf_dest_addr = R_IR2;
        o_rf_dest_data = word_q;
        state_d        = INC2;
      end
      INC1, INC2: begin
        o_rf_wr_en     = 1'b1;
        o_rf_dest_addr = R_IP;
        o_rf_dest_data = ip_inc;
        ip_d           = ip_inc;
        if (state_q == INC1) begin
          state_d = ext_q ? RD2 : DONE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ip_q    <= 16'h0000;
      word_q  <= 16'h0000;
      ext_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ip_q    <= ip_d;
      word_q  <= word_d;
      ext_q   <= ext_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural memory and register file.
module tb_instr_fetch;
  import common_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        rf_wr_en;
  reg_id_e     rf_dest_addr;
  logic [15:0] rf_dest_data;
  reg_id_e     rf_ab_addr;
  logic [15:0] rf_ab_data;

  logic [15:0] mem [0:65535];
  logic [15:0] rf  [0:15];
  int          waits;
  int          wcnt;
  int          cyc;
  int          n_tests;
  int          n_fail;
  logic [15:0] ack_addr [0:3];
  int          n_ack;

  instr_fetch dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .o_busy         (busy),
    .o_done         (done),
    .o_mem_req      (mem_req),
    .o_mem_addr     (mem_addr),
    .i_mem_ack      (mem_ack),
    .i_mem_rdata    (mem_rdata),
    .o_rf_wr_en     (rf_wr_en),
    .o_rf_dest_addr (rf_dest_addr),
    .o_rf_dest_data (rf_dest_data),
    .o_rf_ab_addr   (rf_ab_addr),
    .i_rf_ab_data   (rf_ab_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_ab_data = rf[R_IP];
  assign mem_rdata  = mem[mem_addr];
  assign mem_ack    = mem_req && (wcnt == waits);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_req"}, 32'(mem_req), 32'd0);
    check({tag, "_wr_en"}, 32'(rf_wr_en), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_dest_addr"}, 32'(rf_dest_addr), 32'(R_ZR));
    check({tag, "_dest_data"}, 32'(rf_dest_data), 32'd0);
    check({tag, "_ab_addr"}, 32'(rf_ab_addr), 32'(R_IP));
  endtask

  // Starts a fetch at a negedge; returns the cycle index of the first o_done counted from
  // the start-sampling cycle (0), or -1 if none / aborted.
  task automatic run_fetch(input bit pulse_wb1, input bit abort_rd2,
                           output int done_cyc, output int n_done, output bit addr_ok);
    int      t0;
    bit      pend_we;
    reg_id_e pend_a;
    logic [15:0] pend_d;
    bit      prev_pend;
    logic [15:0] prev_addr;
    bit      ir1_seen;
    done_cyc  = -1;
    n_done    = 0;
    addr_ok   = 1'b1;
    n_ack     = 0;
    pend_we   = 1'b0;
    pend_a    = R_ZR;
    pend_d    = 16'h0;
    prev_pend = 1'b0;
    prev_addr = 16'h0;
    ir1_seen  = 1'b0;
    @(negedge clk);
    start = 1'b1;
    t0    = cyc;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      if (pend_we) rf[pend_a] = pend_d;
      @(negedge clk);
      start = 1'b0;
      if (prev_pend && mem_req && mem_addr != prev_addr) addr_ok = 1'b0;
      prev_pend = mem_req && !mem_ack;
      prev_addr = mem_addr;
      if (mem_req && mem_ack && n_ack < 4) begin
        ack_addr[n_ack] = mem_addr;
        n_ack++;
      end
      if (abort_rd2 && mem_req && ir1_seen) begin
        rst_n = 1'b0;
        return;
      end
      pend_we = rf_wr_en;
      pend_a  = rf_dest_addr;
      pend_d  = rf_dest_data;
      if (rf_wr_en && rf_dest_addr == R_IR1) begin
        ir1_seen = 1'b1;
        if (pulse_wb1) start = 1'b1;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc - t0;
      end
      if (done_cyc >= 0 && (cyc - t0) >= done_cyc + 4) break;
    end
  endtask

  int dc, nd;
  bit aok;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    wcnt    = 0;
    waits   = 0;
    start   = 1'b0;
    rst_n   = 1'b0;
    for (int i = 0; i < 16; i++) rf[i] = 16'h0;
    #1;
    check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // One-word fetch, zero wait.
    mem[16'h0100] = 16'h1234;
    rf[R_IP]  = 16'h0100;
    rf[R_IR2] = 16'hAAAA;
    run_fetch(1'b0, 1'b0, dc, nd, aok);
    check("w1_done_cyc", 32'(dc), 32'd4);
    check("w1_n_done", 32'(nd), 32'd1);
    check("w1_ir1", 32'(rf[R_IR1]), 32'h1234);
    check("w1_ip", 32'(rf[R_IP]), 32'h0101);
    check("w1_ir2", 32'(rf[R_IR2]), 32'hAAAA);

    // Two-word fetch, zero wait.
    mem[16'h0200] = 16'hF00A;
    mem[16'h0201] = 16'hBEEF;
    rf[R_IP] = 16'h0200;
    run_fetch(1'b0, 1'b0, dc, nd, aok);
    check("w2_done_cyc", 32'(dc), 32'd7);
    check("w2_ir1", 32'(rf[R_IR1]), 32'hF00A);
    check("w2_ir2", 32'(rf[R_IR2]), 32'hBEEF);
    check("w2_ip", 32'(rf[R_IP]), 32'h0202);

    // Two-word fetch with 3 wait states per read.
    waits    = 3;
    rf[R_IP]  = 16'h0200;
    rf[R_IR1] = 16'h0;
    rf[R_IR2] = 16'h0;
    run_fetch(1'b0, 1'b0, dc, nd, aok);
    check("ws_done_cyc", 32'(dc), 32'd13);
    check("ws_addr_stable", 32'(aok), 32'd1);
    check("ws_ir1", 32'(rf[R_IR1]), 32'hF00A);
    check("ws_ir2", 32'(rf[R_IR2]), 32'hBEEF);
    check("ws_ip", 32'(rf[R_IP]), 32'h0202);
    waits = 0;

    // IP wraps from FFFF to 0000 between words.
    mem[16'hFFFF] = 16'hF001;
    mem[16'h0000] = 16'h5555;
    rf[R_IP] = 16'hFFFF;
    run_fetch(1'b0, 1'b0, dc, nd, aok);
    check("wrap_n_ack", 32'(n_ack), 32'd2);
    check("wrap_rd2_addr", 32'(ack_addr[1]), 32'h0000);
    check("wrap_ir2", 32'(rf[R_IR2]), 32'h5555);
    check("wrap_ip", 32'(rf[R_IP]), 32'h0001);

    // Reset during RD2.
    waits = 3;
    mem[16'h0300] = 16'hF0F0;
    mem[16'h0301] = 16'h1111;
    rf[R_IP]  = 16'h0300;
    rf[R_IR2] = 16'h2222;
    run_fetch(1'b0, 1'b1, dc, nd, aok);
    #1;
    check("abort_in_rst", 32'(rst_n), 32'd0);
    check_reset_outputs("abort");
    check("abort_ir1", 32'(rf[R_IR1]), 32'hF0F0);
    check("abort_ip", 32'(rf[R_IP]), 32'h0301);
    check("abort_ir2", 32'(rf[R_IR2]), 32'h2222);
    @(negedge clk);
    rst_n = 1'b1;
    waits = 0;

    // Start pulsed while busy in WB1 must be ignored.
    mem[16'h0400] = 16'h0042;
    rf[R_IP] = 16'h0400;
    run_fetch(1'b1, 1'b0, dc, nd, aok);
    check("busy_done_cyc", 32'(dc), 32'd4);
    check("busy_n_done", 32'(nd), 32'd1);
    check("busy_ir1", 32'(rf[R_IR1]), 32'h0042);
    check("busy_ip", 32'(rf[R_IP]), 32'h0401);
    check("busy_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer for the 16-bit core; sits directly upstream of `register_file`. On request it reads IP, fetches one or two instruction words from memory over a req/ack handshake, and writes them into IR1 and IR2 through the register file's single write port. Between words it advances IP by writing IP+1 back, also through that port. The decode stage starts once `o_done` pulses.

## Interface
- `EXT_MASK`, default 16'hF000: IR1 bits examined to decide whether the instruction has a second word.
- `EXT_MATCH`, default 16'hF000: the instruction is two-word when `(IR1 & EXT_MASK) == EXT_MATCH`.
- `i_clk`  in  1  single clock, rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  fetch request, sampled only in IDLE.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle pulse when IR1/IR2 and IP are final.
- `o_mem_req`  out  1  memory read request.
- `o_mem_addr`  out  16  word address.
- `i_mem_ack`  in  1  read complete; `i_mem_rdata` is valid in the same cycle.
- `i_mem_rdata`  in  16  read data.
- `o_rf_wr_en`  out  1  register file write enable.
- `o_rf_dest_addr`  out  reg_id_e  write target.
- `o_rf_dest_data`  out  16  write data.
- `o_rf_ab_addr`  out  reg_id_e  tied to R_IP.
- `i_rf_ab_data`  in  16  current IP from the register file.

## Operation
- States (`fetch_state_e`): IDLE, RD1, WB1, INC1, RD2, WB2, INC2, DONE.
- IDLE: on `i_start`, capture `i_rf_ab_data` into `ip_q`, then go to RD1.
- RD1/RD2:
  - `o_mem_req`=1 and `o_mem_addr`=`ip_q`; both are held stable until the ack.
  - On the edge where `i_mem_ack`=1, latch `i_mem_rdata` into `word_q` and advance to WB1/WB2.
- WB1/WB2:
  - `o_rf_wr_en`=1, `o_rf_dest_addr`=R_IR1 or R_IR2, `o_rf_dest_data`=`word_q`.
  - WB1 also evaluates the two-word test on `word_q` and registers it as `ext_q`.
- INC1/INC2: `o_rf_wr_en`=1, `o_rf_dest_addr`=R_IP, data=`ip_q+1`; `ip_q` updates to `ip_q+1` on the same edge.
- After INC1: go to RD2 if `ext_q`=1, else DONE. After INC2: go to DONE.
- DONE: `o_done`=1 for one cycle, then IDLE.
- One-word instructions leave IR2 unwritten.
- Arithmetic: `ip_q+1` is modulo 2^16, so 16'hFFFF wraps to 16'h0000. No carry or flag output.
- `i_start` is ignored when not in IDLE. `i_start` high in the DONE cycle is not sampled; the next fetch starts from IDLE one cycle later.
- `i_mem_ack` is ignored outside RD1/RD2.
- When a write is not active, `o_rf_wr_en`=0, `o_rf_dest_addr`=R_ZR and `o_rf_dest_data`=0.

## Timing
- Reset (asynchronous, while `i_rst_n`=0):
  - State is IDLE.
  - `o_busy`, `o_done`, `o_mem_req` and `o_rf_wr_en` are 0.
  - `o_mem_addr`=0, `o_rf_dest_addr`=R_ZR, `o_rf_dest_data`=0, `o_rf_ab_addr`=R_IP.
  - `ip_q`, `word_q` and `ext_q` are cleared.
- Reset mid-fetch aborts immediately. Register writes already performed stay in the register file; no further writes are issued.
- All outputs are registered or decoded from state only. There is no combinational path from `i_mem_ack` to any output.
- The ack can arrive in the first request cycle, giving zero wait states. The request drops on the cycle after the ack.
- Latency with zero-wait memory, counted from the `i_start` sampling edge as cycle 0:
  - One-word: RD1=1, WB1=2, INC1=3, DONE=4.
  - Two-word: RD1=1 … INC2=6, DONE=7.
  - Each memory wait cycle adds one cycle.
- Register file writes land on the edge that ends WB or INC. The value is visible on read ports the following cycle.

## Structure
- `fetch_state_e` is added to `common_pkg` next to `reg_id_e`.
- `EXT_MASK` and `EXT_MATCH` stay as module parameters.
- Single module with no sub-module. The FSM, `ip_q`, `word_q` and `ext_q` live in one block.

## Test plan
- One-word fetch: IP=16'h0100, mem[0x0100]=16'h1234, zero-wait. Required: IR1=16'h1234, IP=16'h0101, `o_done` in cycle 4, IR2 unchanged.
- Two-word fetch: IP=16'h0200, mem[0x0200]=16'hF00A, mem[0x0201]=16'hBEEF. Required: IR1=16'hF00A, IR2=16'hBEEF, IP=16'h0202, `o_done` in cycle 7.
- Wait states: ack delayed 3 cycles on each read of the two-word case. Required: `o_mem_addr` stable while `o_mem_req` is high, `o_done` in cycle 13, same final register values.
- Wrap: IP=16'hFFFF, two-word instruction. Required: second read at 16'h0000, final IP=16'h0001.
- Reset mid-fetch: assert `i_rst_n`=0 during RD2. Required: all outputs at reset values immediately; IR1 and IP hold the values written before the reset; IR2 not written.
- Start while busy: pulse `i_start` during WB1. Required: ignored, exactly one `o_done`, IP advanced once per fetched word.
